// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Reservation station in front of the combinational ALU. Decoded ALU/branch
// instructions are buffered until both source operands are known. Entries
// snoop the ALU and load/store result broadcasts to collect missing operands.
// At most one ready entry per cycle is moved onto the registered ALU ports.
//
// Ports
//   clk_in, rst_in         clock, synchronous active-high reset
//   rdy_in                 global enable, low freezes every register
//   flush_in               misprediction clear from the ROB
//   dsp_*                  dispatch request from the decoder
//   rs_full                registered, high once RS_SIZE-1 or more entries are busy
//   alu_cdb_*, lsb_cdb_*   result broadcasts (tag == EMPTY_TAG means idle)
//   op_type_ex .. tag_in_rob   registered ALU inputs
//
// Widths and empty values mirror the project-wide defines.v constants
// (opTypeWidth, dataWidth, immWidth, addrWidth, tagWidth, emptyTag, ...).
//
// Optional feature macro: RS_OLDEST_FIRST_EN
//   defined     : issue picks the oldest ready entry (per-entry age counter)
//   not defined : issue picks the lowest-index ready entry
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 32,
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 5,
    parameter logic [TAG_W-1:0] EMPTY_TAG = {1'b1, {(TAG_W-1){1'b0}}}
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,

    input  logic                dsp_valid,
    input  logic [OP_W-1:0]     dsp_op,
    input  logic [TAG_W-1:0]    dsp_qj,
    input  logic [TAG_W-1:0]    dsp_qk,
    input  logic [DATA_W-1:0]   dsp_vj,
    input  logic [DATA_W-1:0]   dsp_vk,
    input  logic [IMM_W-1:0]    dsp_imm,
    input  logic [ADDR_W-1:0]   dsp_pc,
    input  logic [TAG_W-1:0]    dsp_rob_tag,
    output logic                rs_full,

    input  logic [TAG_W-1:0]    alu_cdb_tag,
    input  logic [DATA_W-1:0]   alu_cdb_data,
    input  logic [TAG_W-1:0]    lsb_cdb_tag,
    input  logic [DATA_W-1:0]   lsb_cdb_data,

    output logic [OP_W-1:0]     op_type_ex,
    output logic [DATA_W-1:0]   data_rs1_ex,
    output logic [DATA_W-1:0]   data_rs2_ex,
    output logic [IMM_W-1:0]    imm_ex,
    output logic [ADDR_W-1:0]   pc_ex,
    output logic [TAG_W-1:0]    tag_in_rob
);

    localparam logic [OP_W-1:0]   EMPTY_OP   = '0;
    localparam logic [DATA_W-1:0] EMPTY_DATA = '0;
    localparam logic [ADDR_W-1:0] EMPTY_ADDR = '0;
    localparam logic [IMM_W-1:0]  EMPTY_IMM  = '0;

    logic [RS_SIZE-1:0] busy;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [TAG_W-1:0]   qj_q   [RS_SIZE];
    logic [TAG_W-1:0]   qk_q   [RS_SIZE];
    logic [DATA_W-1:0]  vj_q   [RS_SIZE];
    logic [DATA_W-1:0]  vk_q   [RS_SIZE];
    logic [IMM_W-1:0]   imm_q  [RS_SIZE];
    logic [ADDR_W-1:0]  pc_q   [RS_SIZE];
    logic [TAG_W-1:0]   rob_q  [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
    // age = number of busy entries dispatched after this one, so it never
    // exceeds RS_SIZE-1 and the largest age is always the oldest entry
    logic [IDX_W-1:0]   age_q  [RS_SIZE];
    logic [IDX_W-1:0]   best_age;
`endif

    logic [RS_SIZE-1:0] ready;
    logic               has_free;
    logic               has_ready;
    logic               do_dsp;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W:0]     busy_cnt;

    logic [TAG_W-1:0]   dsp_qj_r;
    logic [TAG_W-1:0]   dsp_qk_r;
    logic [DATA_W-1:0]  dsp_vj_r;
    logic [DATA_W-1:0]  dsp_vk_r;

    // Readiness and occupancy come from registered state only, so a wakeup
    // captured at one edge can issue at the next edge at the earliest.
    always_comb begin
        ready    = '0;
        busy_cnt = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (qj_q[i] == EMPTY_TAG) && (qk_q[i] == EMPTY_TAG);
            busy_cnt = busy_cnt + (IDX_W+1)'(busy[i]);
        end
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (!busy[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        do_dsp = dsp_valid && has_free;
    end

    // Issue selection: fixed lowest-index priority, or the largest age when
    // oldest-first ordering is compiled in.
    always_comb begin
        has_ready = 1'b0;
        issue_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!has_ready || age_q[i] > best_age)) begin
                has_ready = 1'b1;
                issue_idx = IDX_W'(i);
                best_age  = age_q[i];
            end
        end
`else
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (ready[i]) begin
                has_ready = 1'b1;
                issue_idx = IDX_W'(i);
            end
        end
`endif
    end

    // Same-cycle bypass: an operand being broadcast right now is taken from
    // the bus; the ALU broadcast wins if both buses carry the same tag.
    always_comb begin
        dsp_qj_r = dsp_qj;
        dsp_vj_r = dsp_vj;
        dsp_qk_r = dsp_qk;
        dsp_vk_r = dsp_vk;
        if (dsp_qj != EMPTY_TAG && dsp_qj == alu_cdb_tag) begin
            dsp_qj_r = EMPTY_TAG;
            dsp_vj_r = alu_cdb_data;
        end else if (dsp_qj != EMPTY_TAG && dsp_qj == lsb_cdb_tag) begin
            dsp_qj_r = EMPTY_TAG;
            dsp_vj_r = lsb_cdb_data;
        end
        if (dsp_qk != EMPTY_TAG && dsp_qk == alu_cdb_tag) begin
            dsp_qk_r = EMPTY_TAG;
            dsp_vk_r = alu_cdb_data;
        end else if (dsp_qk != EMPTY_TAG && dsp_qk == lsb_cdb_tag) begin
            dsp_qk_r = EMPTY_TAG;
            dsp_vk_r = lsb_cdb_data;
        end
    end

    // Entry and ALU-port registers. The dispatch slot is non-busy at the
    // start of the cycle, so it never collides with the wakeup loop or the
    // issuing slot. rs_full lags the occupancy by one edge on purpose; the
    // RS_SIZE-1 threshold leaves room for the dispatch already in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy        <= '0;
            rs_full     <= 1'b0;
            op_type_ex  <= EMPTY_OP;
            data_rs1_ex <= EMPTY_DATA;
            data_rs2_ex <= EMPTY_DATA;
            imm_ex      <= EMPTY_IMM;
            pc_ex       <= EMPTY_ADDR;
            tag_in_rob  <= EMPTY_TAG;
        end else if (rdy_in) begin
            rs_full <= (busy_cnt >= (IDX_W+1)'(RS_SIZE-1));
            if (flush_in) begin
                busy        <= '0;
                op_type_ex  <= EMPTY_OP;
                data_rs1_ex <= EMPTY_DATA;
                data_rs2_ex <= EMPTY_DATA;
                imm_ex      <= EMPTY_IMM;
                pc_ex       <= EMPTY_ADDR;
                tag_in_rob  <= EMPTY_TAG;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if (qj_q[i] != EMPTY_TAG && qj_q[i] == alu_cdb_tag) begin
                            qj_q[i] <= EMPTY_TAG;
                            vj_q[i] <= alu_cdb_data;
                        end else if (qj_q[i] != EMPTY_TAG && qj_q[i] == lsb_cdb_tag) begin
                            qj_q[i] <= EMPTY_TAG;
                            vj_q[i] <= lsb_cdb_data;
                        end
                        if (qk_q[i] != EMPTY_TAG && qk_q[i] == alu_cdb_tag) begin
                            qk_q[i] <= EMPTY_TAG;
                            vk_q[i] <= alu_cdb_data;
                        end else if (qk_q[i] != EMPTY_TAG && qk_q[i] == lsb_cdb_tag) begin
                            qk_q[i] <= EMPTY_TAG;
                            vk_q[i] <= lsb_cdb_data;
                        end
`ifdef RS_OLDEST_FIRST_EN
                        // a new arrival makes every waiting entry one older;
                        // an issuing older peer removes one younger count
                        // from nobody, a younger-than-me issue removes one
                        if (!(has_ready && issue_idx == IDX_W'(i))) begin
                            age_q[i] <= age_q[i] + IDX_W'(do_dsp)
                                      - IDX_W'(has_ready && (age_q[i] > age_q[issue_idx]));
                        end
`endif
                    end
                end

                if (has_ready) begin
                    busy[issue_idx] <= 1'b0;
                    op_type_ex      <= op_q[issue_idx];
                    data_rs1_ex     <= vj_q[issue_idx];
                    data_rs2_ex     <= vk_q[issue_idx];
                    imm_ex          <= imm_q[issue_idx];
                    pc_ex           <= pc_q[issue_idx];
                    tag_in_rob      <= rob_q[issue_idx];
                end else begin
                    op_type_ex  <= EMPTY_OP;
                    data_rs1_ex <= EMPTY_DATA;
                    data_rs2_ex <= EMPTY_DATA;
                    imm_ex      <= EMPTY_IMM;
                    pc_ex       <= EMPTY_ADDR;
                    tag_in_rob  <= EMPTY_TAG;
                end

                if (do_dsp) begin
                    busy[free_idx]  <= 1'b1;
                    op_q[free_idx]  <= dsp_op;
                    qj_q[free_idx]  <= dsp_qj_r;
                    vj_q[free_idx]  <= dsp_vj_r;
                    qk_q[free_idx]  <= dsp_qk_r;
                    vk_q[free_idx]  <= dsp_vk_r;
                    imm_q[free_idx] <= dsp_imm;
                    pc_q[free_idx]  <= dsp_pc;
                    rob_q[free_idx] <= dsp_rob_tag;
`ifdef RS_OLDEST_FIRST_EN
                    age_q[free_idx] <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl: a table of directed vectors, a few
// hand-written multi-cycle sequences (fill/rs_full, flush, issue order with a
// rdy_in stall) and a randomized phase compared against a queue-level model.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int RS  = 16;
    localparam int OPW = 6;
    localparam int DW  = 32;
    localparam int IW  = 32;
    localparam int AW  = 32;
    localparam int TW  = 5;
    localparam logic [TW-1:0]  ET  = 5'b10000;
    localparam logic [OPW-1:0] ADD = 6'd1;
    localparam logic [OPW-1:0] SUB = 6'd2;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, flush_in;
    logic            dsp_valid;
    logic [OPW-1:0]  dsp_op;
    logic [TW-1:0]   dsp_qj, dsp_qk, dsp_rob_tag;
    logic [DW-1:0]   dsp_vj, dsp_vk;
    logic [IW-1:0]   dsp_imm;
    logic [AW-1:0]   dsp_pc;
    logic            rs_full;
    logic [TW-1:0]   alu_cdb_tag, lsb_cdb_tag;
    logic [DW-1:0]   alu_cdb_data, lsb_cdb_data;
    logic [OPW-1:0]  op_type_ex;
    logic [DW-1:0]   data_rs1_ex, data_rs2_ex;
    logic [IW-1:0]   imm_ex;
    logic [AW-1:0]   pc_ex;
    logic [TW-1:0]   tag_in_rob;

    int checks   = 0;
    int failures = 0;

    alu_issue_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .dsp_valid    (dsp_valid),
        .dsp_op       (dsp_op),
        .dsp_qj       (dsp_qj),
        .dsp_qk       (dsp_qk),
        .dsp_vj       (dsp_vj),
        .dsp_vk       (dsp_vk),
        .dsp_imm      (dsp_imm),
        .dsp_pc       (dsp_pc),
        .dsp_rob_tag  (dsp_rob_tag),
        .rs_full      (rs_full),
        .alu_cdb_tag  (alu_cdb_tag),
        .alu_cdb_data (alu_cdb_data),
        .lsb_cdb_tag  (lsb_cdb_tag),
        .lsb_cdb_data (lsb_cdb_data),
        .op_type_ex   (op_type_ex),
        .data_rs1_ex  (data_rs1_ex),
        .data_rs2_ex  (data_rs2_ex),
        .imm_ex       (imm_ex),
        .pc_ex        (pc_ex),
        .tag_in_rob   (tag_in_rob)
    );

    always #5 clk_in = ~clk_in;

    // Hard stop in case something wedges the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic           dv;
        logic [OPW-1:0] op;
        logic [TW-1:0]  qj;
        logic [DW-1:0]  vj;
        logic [TW-1:0]  qk;
        logic [DW-1:0]  vk;
        logic [TW-1:0]  rob;
        logic [TW-1:0]  atag;
        logic [DW-1:0]  adata;
        logic [TW-1:0]  ltag;
        logic [DW-1:0]  ldata;
        logic [OPW-1:0] eop;
        logic [DW-1:0]  e1;
        logic [DW-1:0]  e2;
        logic [TW-1:0]  etag;
        logic           efull;
    } vector_t;

    function automatic vector_t row(input logic dv, input logic [OPW-1:0] op,
                                    input logic [TW-1:0] qj, input logic [DW-1:0] vj,
                                    input logic [TW-1:0] qk, input logic [DW-1:0] vk,
                                    input logic [TW-1:0] rob,
                                    input logic [TW-1:0] atag, input logic [DW-1:0] adata,
                                    input logic [TW-1:0] ltag, input logic [DW-1:0] ldata,
                                    input logic [OPW-1:0] eop, input logic [DW-1:0] e1,
                                    input logic [DW-1:0] e2, input logic [TW-1:0] etag);
        vector_t v;
        v.dv = dv; v.op = op; v.qj = qj; v.vj = vj; v.qk = qk; v.vk = vk; v.rob = rob;
        v.atag = atag; v.adata = adata; v.ltag = ltag; v.ldata = ldata;
        v.eop = eop; v.e1 = e1; v.e2 = e2; v.etag = etag; v.efull = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        dsp_valid = 1'b0; dsp_op = '0; dsp_qj = ET; dsp_qk = ET;
        dsp_vj = '0; dsp_vk = '0; dsp_imm = '0; dsp_pc = '0; dsp_rob_tag = '0;
        alu_cdb_tag = ET; alu_cdb_data = '0; lsb_cdb_tag = ET; lsb_cdb_data = '0;
        flush_in = 1'b0; rdy_in = 1'b1;
    endtask

    // Imm/pc are derived from the rob tag so they can be predicted on issue.
    task automatic applyStimulus(input logic [OPW-1:0] op, input logic [TW-1:0] qj,
                                 input logic [DW-1:0] vj, input logic [TW-1:0] qk,
                                 input logic [DW-1:0] vk, input logic [TW-1:0] rob);
        dsp_valid = 1'b1; dsp_op = op; dsp_qj = qj; dsp_vj = vj;
        dsp_qk = qk; dsp_vk = vk; dsp_rob_tag = rob;
        dsp_imm = IW'(rob) + 100; dsp_pc = AW'(rob) * 4;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkIssue(input string name, input logic [OPW-1:0] eop,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                              input logic [TW-1:0] etag);
        checkOutput({name, ".op"},  op_type_ex,  eop);
        checkOutput({name, ".rs1"}, data_rs1_ex, e1);
        checkOutput({name, ".rs2"}, data_rs2_ex, e2);
        checkOutput({name, ".tag"}, tag_in_rob,  etag);
        checkOutput({name, ".imm"}, imm_ex, (eop != 0) ? IW'(etag) + 100 : '0);
        checkOutput({name, ".pc"},  pc_ex,  (eop != 0) ? AW'(etag) * 4 : '0);
    endtask

    // ---------------- behavioural reference model ----------------
    // Each slot keeps its fields plus a dispatch sequence number; order is
    // decided by comparing sequence numbers rather than tracking ages.
    logic           mb   [RS];
    logic [OPW-1:0] mop  [RS];
    logic [TW-1:0]  mqj  [RS];
    logic [TW-1:0]  mqk  [RS];
    logic [DW-1:0]  mvj  [RS];
    logic [DW-1:0]  mvk  [RS];
    logic [IW-1:0]  mimm [RS];
    logic [AW-1:0]  mpc  [RS];
    logic [TW-1:0]  mrob [RS];
    longint         mseq [RS];
    longint         seqCtr;
    logic [OPW-1:0] xop;
    logic [DW-1:0]  x1, x2;
    logic [IW-1:0]  ximm;
    logic [AW-1:0]  xpc;
    logic [TW-1:0]  xtag;
    logic           xfull;

    task automatic modelReset();
        for (int i = 0; i < RS; i++) mb[i] = 1'b0;
        seqCtr = 0;
        xop = '0; x1 = '0; x2 = '0; ximm = '0; xpc = '0; xtag = ET; xfull = 1'b0;
    endtask

    function automatic logic [DW-1:0] snoop(input logic [TW-1:0] q, input logic [DW-1:0] v, output logic [TW-1:0] qo);
        qo = q;
        if (q != ET && q == alu_cdb_tag) begin qo = ET; return alu_cdb_data; end
        if (q != ET && q == lsb_cdb_tag) begin qo = ET; return lsb_cdb_data; end
        return v;
    endfunction

    task automatic modelStep();
        int cnt, pick, freeSlot;
        logic [TW-1:0] nq;
        if (!rdy_in) return;
        cnt = 0;
        for (int i = 0; i < RS; i++) cnt += int'(mb[i]);
        xfull = (cnt >= RS - 1);
        if (flush_in) begin
            for (int i = 0; i < RS; i++) mb[i] = 1'b0;
            xop = '0; x1 = '0; x2 = '0; ximm = '0; xpc = '0; xtag = ET;
            return;
        end
        pick = -1;
        for (int i = 0; i < RS; i++) begin
            if (mb[i] && mqj[i] == ET && mqk[i] == ET) begin
`ifdef RS_OLDEST_FIRST_EN
                if (pick < 0 || mseq[i] < mseq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        freeSlot = -1;
        for (int i = RS - 1; i >= 0; i--) if (!mb[i]) freeSlot = i;
        if (pick >= 0) begin
            xop = mop[pick]; x1 = mvj[pick]; x2 = mvk[pick];
            ximm = mimm[pick]; xpc = mpc[pick]; xtag = mrob[pick];
        end else begin
            xop = '0; x1 = '0; x2 = '0; ximm = '0; xpc = '0; xtag = ET;
        end
        for (int i = 0; i < RS; i++) begin
            if (mb[i]) begin
                mvj[i] = snoop(mqj[i], mvj[i], nq); mqj[i] = nq;
                mvk[i] = snoop(mqk[i], mvk[i], nq); mqk[i] = nq;
            end
        end
        if (pick >= 0) mb[pick] = 1'b0;
        if (dsp_valid && freeSlot >= 0) begin
            mb[freeSlot]   = 1'b1;
            mop[freeSlot]  = dsp_op;
            mvj[freeSlot]  = snoop(dsp_qj, dsp_vj, nq); mqj[freeSlot] = nq;
            mvk[freeSlot]  = snoop(dsp_qk, dsp_vk, nq); mqk[freeSlot] = nq;
            mimm[freeSlot] = dsp_imm;
            mpc[freeSlot]  = dsp_pc;
            mrob[freeSlot] = dsp_rob_tag;
            mseq[freeSlot] = seqCtr;
            seqCtr++;
        end
    endtask

    function automatic logic [TW-1:0] randTag(input int emptyPct);
        if (int'($urandom_range(99)) < emptyPct) return ET;
        return TW'($urandom_range(7));
    endfunction

    vector_t vec [18];
    logic [TW-1:0] firstTag, secondTag;

    initial begin
        // directed vector table
        for (int i = 0; i < 5; i++)
            vec[i] = row(0, 0, ET, 0, ET, 0, 0, ET, 0, ET, 0, 0, 0, 0, ET);
        vec[5]  = row(1, ADD, ET, 5, ET, 7, 3, ET, 0, ET, 0,   0,   0, 0, ET);
        vec[6]  = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   ADD, 5, 7, 3);
        vec[7]  = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   0,   0, 0, ET);
        vec[8]  = row(1, SUB, 4,  0, ET, 9, 6, ET, 0, ET, 0,   0,   0, 0, ET);
        vec[9]  = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   0,   0, 0, ET);
        vec[10] = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, 4, 100,  0,   0, 0, ET);
        vec[11] = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   SUB, 100, 9, 6);
        vec[12] = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   0,   0, 0, ET);
        vec[13] = row(1, SUB, 4,  0, ET, 9, 7, ET, 0, 4, 55,   0,   0, 0, ET);
        vec[14] = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   SUB, 55, 9, 7);
        vec[15] = row(1, ADD, ET, 1, 8,  0, 12, 8, 77, ET, 0,  0,   0, 0, ET);
        vec[16] = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   ADD, 1, 77, 12);
        vec[17] = row(0, 0,   ET, 0, ET, 0, 0, ET, 0, ET, 0,   0,   0, 0, ET);

        idleInputs();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        checkIssue("reset", 0, 0, 0, ET);
        checkOutput("reset.full", rs_full, 0);

        for (int i = 0; i < 18; i++) begin
            idleInputs();
            if (vec[i].dv)
                applyStimulus(vec[i].op, vec[i].qj, vec[i].vj, vec[i].qk, vec[i].vk, vec[i].rob);
            alu_cdb_tag = vec[i].atag; alu_cdb_data = vec[i].adata;
            lsb_cdb_tag = vec[i].ltag; lsb_cdb_data = vec[i].ldata;
            tick();
            checkIssue($sformatf("vec%0d", i), vec[i].eop, vec[i].e1, vec[i].e2, vec[i].etag);
            checkOutput($sformatf("vec%0d.full", i), rs_full, vec[i].efull);
        end

        // fill 15 waiting entries; rs_full follows occupancy one edge later
        for (int k = 0; k < 15; k++) begin
            idleInputs();
            applyStimulus(ADD, TW'(k), 0, ET, DW'(k), TW'(k));
            tick();
        end
        idleInputs();
        checkOutput("fill.full_lag", rs_full, 0);
        tick();
        checkOutput("fill.full", rs_full, 1);
        alu_cdb_tag = 5; alu_cdb_data = 123;
        tick();
        idleInputs();
        checkOutput("fill.wake_full", rs_full, 1);
        checkIssue("fill.wake", 0, 0, 0, ET);
        tick();
        checkIssue("fill.issue", ADD, 123, 5, 5);
        checkOutput("fill.issue_full", rs_full, 1);
        tick();
        checkOutput("fill.release", rs_full, 0);
        checkIssue("fill.after", 0, 0, 0, ET);

        // flush with a simultaneous ready dispatch: everything is discarded
        applyStimulus(ADD, ET, 1, ET, 2, 9);
        flush_in = 1'b1;
        tick();
        idleInputs();
        checkIssue("flush", 0, 0, 0, ET);
        tick();
        checkIssue("flush.dsp_dropped", 0, 0, 0, ET);
        for (int t = 1; t <= 4; t++) begin
            lsb_cdb_tag = TW'(t); lsb_cdb_data = 200;
            tick();
            checkIssue($sformatf("flush.wake%0d", t), 0, 0, 0, ET);
        end
        idleInputs();
        tick();
        checkIssue("flush.idle", 0, 0, 0, ET);
        checkOutput("flush.full", rs_full, 0);

        // issue order: slot 2 older, slot 0 newer, both woken together
        applyStimulus(ADD, 10, 0, ET, 1, 20); tick();
        applyStimulus(ADD, 11, 0, ET, 2, 21); tick();
        applyStimulus(SUB, 12, 0, ET, 3, 22); tick();
        idleInputs();
        alu_cdb_tag = 10; alu_cdb_data = 1;
        tick();
        idleInputs();
        tick();
        checkIssue("order.x", ADD, 1, 1, 20);
        applyStimulus(ADD, 12, 0, ET, 4, 23);
        tick();
        idleInputs();
        checkIssue("order.dsp", 0, 0, 0, ET);
        alu_cdb_tag = 12; alu_cdb_data = 32'hAB;
        tick();
        idleInputs();
        checkIssue("order.wake", 0, 0, 0, ET);
`ifdef RS_OLDEST_FIRST_EN
        firstTag = 22; secondTag = 23;
`else
        firstTag = 23; secondTag = 22;
`endif
        tick();
        checkOutput("order.first", tag_in_rob, firstTag);
        checkOutput("order.first_rs1", data_rs1_ex, 32'hAB);
        rdy_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput($sformatf("order.hold%0d", s), tag_in_rob, firstTag);
        end
        rdy_in = 1'b1;
        tick();
        checkOutput("order.second", tag_in_rob, secondTag);
        checkOutput("order.second_rs1", data_rs1_ex, 32'hAB);
        tick();
        checkIssue("order.empty", 0, 0, 0, ET);

        // randomized phase against the reference model
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        modelReset();
        for (int c = 0; c < 500; c++) begin
            rdy_in       = ($urandom_range(9) != 0);
            flush_in     = ($urandom_range(39) == 0);
            dsp_valid    = ($urandom_range(9) < 6);
            dsp_op       = OPW'($urandom_range(1, 63));
            dsp_qj       = randTag(50);
            dsp_qk       = randTag(50);
            dsp_vj       = $urandom;
            dsp_vk       = $urandom;
            dsp_imm      = $urandom;
            dsp_pc       = $urandom;
            dsp_rob_tag  = TW'($urandom_range(15));
            alu_cdb_tag  = randTag(40);
            alu_cdb_data = $urandom;
            lsb_cdb_tag  = randTag(60);
            lsb_cdb_data = $urandom;
            modelStep();
            tick();
            checkOutput($sformatf("rnd%0d.op", c),  op_type_ex,  xop);
            checkOutput($sformatf("rnd%0d.rs1", c), data_rs1_ex, x1);
            checkOutput($sformatf("rnd%0d.rs2", c), data_rs2_ex, x2);
            checkOutput($sformatf("rnd%0d.imm", c), imm_ex,      ximm);
            checkOutput($sformatf("rnd%0d.pc", c),  pc_ex,       xpc);
            checkOutput($sformatf("rnd%0d.tag", c), tag_in_rob,  xtag);
            checkOutput($sformatf("rnd%0d.full", c), rs_full,    xfull);
        end
        idleInputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
